// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: chooses PC advance/hold/redirect and runs a single-outstanding imem handshake.
// Optional FETCH_CTRL_PERF_EN adds saturating fetched/bubble counters.
//
// state | meaning
// IDLE  | just out of reset, no strobes
// ISSUE | send a request at pc_in, or take a branch/halt/stall
// WAIT  | one request outstanding, waiting for imem_ready
// HALT  | parked until resume
module fetch_controller #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] pc_in,
   input  logic [WORD_SIZE-1:0] pc_plus2,
   input  logic                 imem_ready,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic [WORD_SIZE-1:0] branch_target,
   input  logic                 halt,
   input  logic                 resume,
   output logic                 imem_req,
   output logic                 pc_write,
   output logic [WORD_SIZE-1:0] pc_next,
   output logic                 if_id_write,
   output logic                 if_id_flush,
   output logic [1:0]           state
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [15:0]          perf_fetched,
   output logic [15:0]          perf_bubbles
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_redir_pend;
   logic [WORD_SIZE-1:0]   r_redir_addr;
   logic                   w_drop;
   logic                   w_unused_pc;

   // The request address is pc_in itself, routed outside this block.
   assign w_unused_pc = ^pc_in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_redir_pend <= 1'b0;
         r_redir_addr <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_WAIT) begin
            if (imem_ready) begin
               r_redir_pend <= 1'b0;
            end else if (branch_taken) begin
               r_redir_pend <= 1'b1;
               r_redir_addr <= branch_target;
            end
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      imem_req     = 1'b0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      pc_next      = pc_plus2;
      w_drop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            pc_next      = '0;
            w_next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (branch_taken) begin
               pc_write    = 1'b1;
               pc_next     = branch_target;
               if_id_flush = 1'b1;
            end else if (halt) begin
               w_next_state = S_HALT;
            end else if (!stall) begin
               imem_req     = 1'b1;
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            // A live branch beats one latched earlier in this same wait.
            if (branch_taken) begin
               pc_next = branch_target;
            end else if (r_redir_pend) begin
               pc_next = r_redir_addr;
            end
            if (imem_ready) begin
               w_next_state = S_ISSUE;
               if (branch_taken || r_redir_pend) begin
                  if_id_flush = 1'b1;
                  pc_write    = 1'b1;
                  w_drop      = 1'b1;
               end else if (stall) begin
                  w_drop = 1'b1;
               end else begin
                  if_id_write = 1'b1;
                  pc_write    = 1'b1;
               end
            end
         end
         S_HALT: begin
            if (resume) begin
               w_next_state = S_ISSUE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign state = r_state;

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else begin
         if (if_id_write && (perf_fetched != 16'hFFFF)) begin
            perf_fetched <= perf_fetched + 16'd1;
         end
         if (w_drop && (perf_bubbles != 16'hFFFF)) begin
            perf_bubbles <= perf_bubbles + 16'd1;
         end
      end
   end
`else
   logic w_unused_drop;
   assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios, a behavioural fetch model checked every cycle,
// and literal checks on the PC/request address sequences. Honours FETCH_CTRL_PERF_EN.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] tb_pc;
   logic [15:0] pc_plus2;
   logic        imem_ready;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        halt;
   logic        resume;
   logic        imem_req;
   logic        pc_write;
   logic [15:0] pc_next;
   logic        if_id_write;
   logic        if_id_flush;
   logic [1:0]  state;
`ifdef FETCH_CTRL_PERF_EN
   logic [15:0] perf_fetched;
   logic [15:0] perf_bubbles;
`endif

   assign pc_plus2 = tb_pc + 16'd2;

   fetch_controller #(.WORD_SIZE(16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_in         (tb_pc),
      .pc_plus2      (pc_plus2),
      .imem_ready    (imem_ready),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt          (halt),
      .resume        (resume),
      .imem_req      (imem_req),
      .pc_write      (pc_write),
      .pc_next       (pc_next),
      .if_id_write   (if_id_write),
      .if_id_flush   (if_id_flush),
      .state         (state)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_bubbles  (perf_bubbles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode follows the architectural state numbering.
   int          m_mode = 0;
   bit          m_pend = 0;
   logic [15:0] m_addr = 16'h0;
   logic [15:0] m_fetched = 16'h0;
   logic [15:0] m_bubbles = 16'h0;
   int          n_mode;
   bit          n_pend;
   logic [15:0] n_addr;
   bit          e_req, e_pw, e_wr, e_fl, e_drop;
   logic [15:0] e_pn;

   logic [15:0] wlog[$];
   logic [15:0] rlog[$];
   int          flush_cnt = 0;
   int          halt_strobes = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   bit          req_pending = 0;

   task automatic model_reset();
      m_mode = 0; m_pend = 0; m_addr = 16'h0; m_fetched = 16'h0; m_bubbles = 16'h0;
   endtask

   task automatic model_eval();
      e_req = 0; e_pw = 0; e_wr = 0; e_fl = 0; e_drop = 0; e_pn = 16'h0;
      if (!reset_n) begin
         model_reset();
         n_mode = 0; n_pend = 0; n_addr = 16'h0;
         return;
      end
      n_mode = m_mode; n_pend = m_pend; n_addr = m_addr;
      case (m_mode)
         0: n_mode = 1;
         1: begin
            if (branch_taken) begin
               e_pw = 1; e_fl = 1; e_pn = branch_target;
            end else if (halt) begin
               n_mode = 3;
            end else if (!stall) begin
               e_req = 1; n_mode = 2;
            end
         end
         2: begin
            if (imem_ready) begin
               n_mode = 1; n_pend = 0;
               if (branch_taken || m_pend) begin
                  e_fl = 1; e_pw = 1; e_drop = 1;
                  e_pn = branch_taken ? branch_target : m_addr;
               end else if (stall) begin
                  e_drop = 1;
               end else begin
                  e_wr = 1; e_pw = 1; e_pn = tb_pc + 16'd2;
               end
            end else if (branch_taken) begin
               n_pend = 1; n_addr = branch_target;
            end
         end
         default: if (resume) n_mode = 1;
      endcase
   endtask

   // Compare process: inputs settle at the falling edge, outputs checked 2ns later.
   initial forever begin
      @(negedge clk);
      #2;
      model_eval();
      chk("state", 16'(state), 16'(m_mode));
      chk("imem_req", 16'(imem_req), 16'(e_req));
      chk("pc_write", 16'(pc_write), 16'(e_pw));
      chk("if_id_write", 16'(if_id_write), 16'(e_wr));
      chk("if_id_flush", 16'(if_id_flush), 16'(e_fl));
      if (e_pw || m_mode == 0) chk("pc_next", pc_next, e_pn);
`ifdef FETCH_CTRL_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
      if (pc_write) wlog.push_back(pc_next);
      if (imem_req) begin
         rlog.push_back(tb_pc);
         req_pending = 1;
      end
      if (if_id_flush) flush_cnt++;
      if (m_mode == 3 && (imem_req || pc_write || if_id_write || if_id_flush)) halt_strobes++;
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         m_mode = n_mode; m_pend = n_pend; m_addr = n_addr;
         if (e_pw) tb_pc = e_pn;
         if (e_wr && m_fetched != 16'hFFFF) m_fetched = m_fetched + 16'd1;
         if (e_drop && m_bubbles != 16'hFFFF) m_bubbles = m_bubbles + 16'd1;
      end
   end

   // Instruction memory: answers each request mem_lat cycles later with a one-cycle ready.
   initial forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
         mem_cnt = 0; req_pending = 0; imem_ready = 1'b0;
      end else begin
         if (req_pending) begin
            mem_cnt = mem_lat; req_pending = 0;
         end
         if (mem_cnt == 1) begin
            imem_ready = 1'b1; mem_cnt = 0;
         end else begin
            imem_ready = 1'b0;
            if (mem_cnt > 1) mem_cnt--;
         end
      end
   end

   task automatic wait_mode(input int m);
      int n = 0;
      @(negedge clk);
      while (m_mode != m && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (m_mode != m) begin
         checks++; errors++;
         $display("FAIL wait_mode: mode %0d expected %0d", m_mode, m);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected < 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; tb_pc = 16'h0000; imem_ready = 1'b0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = 16'h0; halt = 1'b0; resume = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk("reset_state", 16'(state), 16'h0);
      chk("reset_pc_next", pc_next, 16'h0);
      chk("reset_strobes", 16'({imem_req, pc_write, if_id_write, if_id_flush}), 16'h0);

      // Steady-state fetch from 0 with one-cycle memory.
      @(negedge clk);
      reset_n = 1'b1;
      wlog.delete(); rlog.delete();
      repeat (8) @(negedge clk);
      chk("seq_writes", 16'(wlog.size()), 16'd3);
      if (wlog.size() == 3) begin
         chk("seq_pc0", wlog[0], 16'h0002);
         chk("seq_pc1", wlog[1], 16'h0004);
         chk("seq_pc2", wlog[2], 16'h0006);
      end

      // Branch while waiting, response three cycles later.
      mem_lat = 4;
      wait_mode(2);
      branch_taken = 1'b1; branch_target = 16'h0040;
      wlog.delete(); rlog.delete(); flush_cnt = 0;
      @(negedge clk);
      branch_taken = 1'b0;
      repeat (5) @(negedge clk);
      chk("wait_br_pc", (wlog.size() > 0) ? wlog[0] : 16'hDEAD, 16'h0040);
      chk("wait_br_req", (rlog.size() > 0) ? rlog[0] : 16'hDEAD, 16'h0040);
      chk("wait_br_flush", 16'(flush_cnt), 16'd1);

      // Stall as the response arrives at 0x0010.
      mem_lat = 1;
      wait_mode(1);
      branch_taken = 1'b1; branch_target = 16'h0010;
      @(negedge clk);
      branch_taken = 1'b0;
      wlog.delete(); rlog.delete();
      @(negedge clk);
      stall = 1'b1;
      repeat (3) @(negedge clk);
      stall = 1'b0;
      repeat (3) @(negedge clk);
      chk("stall_req0", (rlog.size() > 0) ? rlog[0] : 16'hDEAD, 16'h0010);
      chk("stall_req1", (rlog.size() > 1) ? rlog[1] : 16'hDEAD, 16'h0010);
      chk("stall_first_write", (wlog.size() > 0) ? wlog[0] : 16'hDEAD, 16'h0012);

      // Halt: branch and stall ignored, resume after 5 halted cycles.
      wait_mode(1);
      halt = 1'b1;
      halt_strobes = 0;
      @(negedge clk);
      halt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0099; stall = 1'b1;
      @(negedge clk);
      branch_taken = 1'b0;
      repeat (3) @(negedge clk);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0; stall = 1'b0;
      #2;
      chk("halt_strobes", 16'(halt_strobes), 16'd0);
      chk("resume_req", 16'(imem_req), 16'd1);
      chk("resume_state", 16'(state), 16'd1);

      // PC wrap at 0xFFFE.
      wait_mode(1);
      branch_taken = 1'b1; branch_target = 16'hFFFE;
      @(negedge clk);
      branch_taken = 1'b0;
      wlog.delete();
      repeat (3) @(negedge clk);
      chk("wrap_pc", (wlog.size() > 0) ? wlog[0] : 16'hDEAD, 16'h0000);

      // Branch and ready together in WAIT.
      wait_mode(2);
      branch_taken = 1'b1; branch_target = 16'h0020;
      wlog.delete(); flush_cnt = 0;
      @(negedge clk);
      branch_taken = 1'b0;
      mem_lat = 4;
      chk("same_cycle_pc", (wlog.size() == 1) ? wlog[0] : 16'hDEAD, 16'h0020);
      chk("same_cycle_flush", 16'(flush_cnt), 16'd1);

      // Two branches during one wait: the later target wins.
      wait_mode(2);
      branch_taken = 1'b1; branch_target = 16'h0030;
      wlog.delete();
      @(negedge clk);
      branch_target = 16'h0050;
      @(negedge clk);
      branch_taken = 1'b0;
      repeat (3) @(negedge clk);
      chk("last_wins_pc", (wlog.size() > 0) ? wlog[0] : 16'hDEAD, 16'h0050);

      // Asynchronous reset in the middle of a wait.
      wait_mode(2);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_state", 16'(state), 16'h0);
      chk("rst_mid_outs", 16'({imem_req, pc_write, if_id_write, if_id_flush}), 16'h0);
      chk("rst_mid_pc_next", pc_next, 16'h0);
`ifdef FETCH_CTRL_PERF_EN
      chk("rst_mid_fetched", perf_fetched, 16'h0);
      chk("rst_mid_bubbles", perf_bubbles, 16'h0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      mem_lat = 1;
      repeat (8) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
